// File: rtl/fp_result_packer_if.sv
// Handshake and payload bundle between the adder result register, the packer and its consumer.
interface fp_result_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        s_outR;
  logic [7:0]  exp_outR;
  logic [23:0] mant_outR;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;

  // Upstream/consumer side: drives the adder result and the result-ready.
  modport master (
    output in_valid, s_outR, exp_outR, mant_outR, res_ready,
    input  in_ready, res_valid, res_data
  );

  // Packer side.
  modport slave (
    input  in_valid, s_outR, exp_outR, mant_outR, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/fp_result_packer.sv
// Packs adder results into IEEE-754 single words and buffers them in a 2-entry FIFO.
// Optional statistics (sticky flags, pop counter) enabled by macro FP_PACK_STATS_EN.
module fp_result_packer (
  input  logic                clk,
  input  logic                rst,
  fp_result_packer_if.slave   bus,
  output logic                flag_unnorm,
  output logic                flag_ovf,
  output logic [15:0]         res_count
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned COUNT_W = 2;

  logic [COUNT_W-1:0] count;
  logic               wr_ptr;
  logic               rd_ptr;
  logic [WORD_W-1:0]  mem [2];
  logic [WORD_W-1:0]  packed_word;
  logic               push;
  logic               pop;

  assign bus.in_ready  = (count != COUNT_W'(2));
  assign bus.res_valid = (count != COUNT_W'(0));
  assign bus.res_data  = bus.res_valid ? mem[rd_ptr] : WORD_W'(0);

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.res_valid && bus.res_ready;

  // Zero mantissa wins over everything and forces +0; exponent 255 collapses to infinity.
  always_comb begin
    packed_word = {bus.s_outR, bus.exp_outR, bus.mant_outR[22:0]};
    if (bus.mant_outR == 24'h0) begin
      packed_word = WORD_W'(0);
    end else if (bus.exp_outR == 8'hFF) begin
      packed_word = {bus.s_outR, 8'hFF, 23'h0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= COUNT_W'(0);
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= WORD_W'(0);
      mem[1] <= WORD_W'(0);
    end else begin
      if (push) begin
        mem[wr_ptr] <= packed_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FP_PACK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_unnorm <= 1'b0;
      flag_ovf    <= 1'b0;
      res_count   <= 16'h0;
    end else begin
      if (push && (bus.exp_outR == 8'hFF)) begin
        flag_ovf <= 1'b1;
      end
      if (push && (bus.mant_outR != 24'h0) && !bus.mant_outR[23]) begin
        flag_unnorm <= 1'b1;
      end
      if (pop) begin
        res_count <= res_count + 16'd1;
      end
    end
  end
`else
  assign flag_unnorm = 1'b0;
  assign flag_ovf    = 1'b0;
  assign res_count   = 16'h0;
`endif

endmodule

// File: tb/tb_fp_result_packer.sv
// Directed self-checking bench for fp_result_packer; expectations follow the build's stats macro.
module tb_fp_result_packer;

`ifdef FP_PACK_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic        clk;
  logic        rst;
  logic        flag_unnorm;
  logic        flag_ovf;
  logic [15:0] res_count;
  int          pass_cnt;
  int          total_cnt;

  fp_result_packer_if bus ();

  fp_result_packer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flag_unnorm (flag_unnorm),
    .flag_ovf    (flag_ovf),
    .res_count   (res_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [23:0] m);
    bus.in_valid  = v;
    bus.s_outR    = s;
    bus.exp_outR  = e;
    bus.mant_outR = m;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    bus.res_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.res_data !== 32'h0) $display("FAIL reset_data got %h want 0", bus.res_data); else pass_cnt++;
    total_cnt++; if ({flag_ovf, flag_unnorm} !== 2'b00) $display("FAIL reset_flags got %b want 00", {flag_ovf, flag_unnorm}); else pass_cnt++;
    total_cnt++; if (res_count !== 16'h0) $display("FAIL reset_count got %h want 0", res_count); else pass_cnt++;
  endtask

  task automatic test_normal();
    bus.res_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h7F, 24'h800000);
    tick();
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    total_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL normal_valid got %b want 1", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.res_data !== 32'h3F80_0000) $display("FAIL normal_data got %h want 3f800000", bus.res_data); else pass_cnt++;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL normal_popped got %b want 0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (res_count !== 16'(STATS)) $display("FAIL normal_count got %h want %h", res_count, 16'(STATS)); else pass_cnt++;
    total_cnt++; if (flag_unnorm !== 1'b0) $display("FAIL normal_unnorm got %b want 0", flag_unnorm); else pass_cnt++;
  endtask

  task automatic test_zero();
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b1, 8'h85, 24'h000000);
    tick();
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    total_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL zero_valid got %b want 1", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.res_data !== 32'h0000_0000) $display("FAIL zero_data got %h want 00000000", bus.res_data); else pass_cnt++;
    bus.res_ready = 1'b1;
    tick();
    total_cnt++; if (res_count !== 16'(2 * STATS)) $display("FAIL zero_count got %h want %h", res_count, 16'(2 * STATS)); else pass_cnt++;
  endtask

  task automatic test_ovf();
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b1, 8'hFF, 24'hC00000);
    tick();
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    total_cnt++; if (bus.res_data !== 32'hFF80_0000) $display("FAIL ovf_data got %h want ff800000", bus.res_data); else pass_cnt++;
    total_cnt++; if (flag_ovf !== 1'(STATS)) $display("FAIL ovf_flag got %b want %b", flag_ovf, 1'(STATS)); else pass_cnt++;
    bus.res_ready = 1'b1;
    tick();
    tick();
    total_cnt++; if (flag_ovf !== 1'(STATS)) $display("FAIL ovf_sticky got %b want %b", flag_ovf, 1'(STATS)); else pass_cnt++;
    total_cnt++; if (res_count !== 16'(3 * STATS)) $display("FAIL ovf_count got %h want %h", res_count, 16'(3 * STATS)); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h80, 24'hA00000);
    tick();
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready1 got %b want 1", bus.in_ready); else pass_cnt++;
    drive(1'b1, 1'b0, 8'h81, 24'hC00000);
    tick();
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_ready2 got %b want 0", bus.in_ready); else pass_cnt++;
    drive(1'b1, 1'b1, 8'h82, 24'h900000);
    tick();
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL b2b_full got %b want 0", bus.in_ready); else pass_cnt++;
    total_cnt++; if (bus.res_data !== 32'h4020_0000) $display("FAIL b2b_hold got %h want 40200000", bus.res_data); else pass_cnt++;
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    bus.res_ready = 1'b1;
    tick();
    total_cnt++; if (bus.res_data !== 32'h40C0_0000) $display("FAIL b2b_second got %h want 40c00000", bus.res_data); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_ready3 got %b want 1", bus.in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (res_count !== 16'(5 * STATS)) $display("FAIL b2b_count got %h want %h", res_count, 16'(5 * STATS)); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h7F, 24'h800000);
    tick();
    bus.res_ready = 1'b1;
    drive(1'b1, 1'b0, 8'h80, 24'h400000);
    tick();
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    total_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL sim_valid got %b want 1", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.res_data !== 32'h4040_0000) $display("FAIL sim_data got %h want 40400000", bus.res_data); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL sim_ready got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (flag_unnorm !== 1'(STATS)) $display("FAIL sim_unnorm got %b want %b", flag_unnorm, 1'(STATS)); else pass_cnt++;
    tick();
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL sim_empty got %b want 0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (res_count !== 16'(7 * STATS)) $display("FAIL sim_count got %h want %h", res_count, 16'(7 * STATS)); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h7F, 24'h800000);
    tick();
    tick();
    total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL mid_full got %b want 0", bus.in_ready); else pass_cnt++;
    bus.res_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", bus.res_valid); else pass_cnt++;
    total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", bus.in_ready); else pass_cnt++;
    total_cnt++; if (res_count !== 16'h0) $display("FAIL mid_count got %h want 0", res_count); else pass_cnt++;
    total_cnt++; if ({flag_ovf, flag_unnorm} !== 2'b00) $display("FAIL mid_flags got %b want 00", {flag_ovf, flag_unnorm}); else pass_cnt++;
    total_cnt++; if (bus.res_data !== 32'h0) $display("FAIL mid_data got %h want 0", bus.res_data); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus.res_ready = 1'b0;
    drive(1'b0, 1'b0, 8'h0, 24'h0);
    test_reset();
    test_normal();
    test_zero();
    test_ovf();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fp_result_packer.md
FP_RESULT_PACKER -- requirements
Module: fp_result_packer

Interface
REQ-001 Parameter: none; FIFO depth fixed at 2 entries.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  result-register contents valid this cycle (adder done).
REQ-005 in_ready  output  1  packer can accept; equals FIFO not full.
REQ-006 s_outR  input  1  result sign.
REQ-007 exp_outR  input  8  result biased exponent.
REQ-008 mant_outR  input  24  result mantissa, bit 23 = hidden bit.
REQ-009 res_valid  output  1  res_data holds a packed result.
REQ-010 res_ready  input  1  consumer accepts res_data.
REQ-011 res_data  output  32  IEEE-754 single word {sign, exp[7:0], frac[22:0]}.
REQ-012 flag_unnorm  output  1  sticky: a non-zero, unnormalised mantissa was accepted.
REQ-013 flag_ovf  output  1  sticky: an exponent-255 result was accepted.
REQ-014 res_count  output  16  number of results popped.

Function
REQ-015 Push = in_valid && in_ready; pop = res_valid && res_ready.
REQ-016 Packing on push: mant_outR == 0 packs as 32'h0000_0000, sign forced positive.
REQ-017 Packing on push: exp_outR == 8'hFF packs as {s_outR, 8'hFF, 23'h0} (infinity) and sets flag_ovf.
REQ-018 Packing on push, otherwise: packs as {s_outR, exp_outR, mant_outR[22:0]}.
REQ-019 Packing on push: if mant_outR != 0 and mant_outR[23] == 0, the word packs unchanged and flag_unnorm is set.
REQ-020 FIFO is 2 entries with 2-bit occupancy count (0..2), 1-bit write pointer and 1-bit read pointer; each pointer wraps 1 -> 0.
REQ-021 Latency: a word pushed at edge N appears on res_data, with res_valid high, after edge N when the FIFO was empty; otherwise it appears in order behind older entries.
REQ-022 res_valid = (count != 0); res_data = entry at the read pointer.
REQ-023 res_data is held stable while res_valid && !res_ready.
REQ-024 in_ready = (count != 2); in_ready shall not depend combinationally on res_ready.
REQ-025 Simultaneous push and pop with count 1: count stays 1, and both pointers advance.
REQ-026 When count is 2, a push is not possible; a pop alone takes count to 1.
REQ-027 A pop with count 0 is impossible because res_valid is low; pointers and count do not change.
REQ-028 in_valid while in_ready is low has no effect; the input is not latched, and the upstream holds the result register.
REQ-029 res_count increments by 1 per pop and wraps 16'hFFFF -> 16'h0000.
REQ-030 flag_unnorm and flag_ovf stay set until reset.

Reset
REQ-031 On rst high at a clock edge: count = 0, pointers = 0, res_valid = 0, res_data = 0, in_ready = 1, flags = 0, res_count = 0.
REQ-032 Reset mid-operation discards all stored entries; no pop is signalled in the reset cycle.
REQ-033 Reset dominates a simultaneous push or pop.

Configuration
REQ-034 Macro FP_PACK_STATS_EN: when defined, flag_ovf, flag_unnorm and res_count are implemented as in REQ-013, REQ-012, REQ-014, REQ-017, REQ-019, REQ-029 and REQ-030.
REQ-035 When FP_PACK_STATS_EN is not defined: the ports still exist, are tied to 0, and no stats registers are inferred; packing is identical.

Verification
REQ-036 Push s=0, exp=8'h7F, mant=24'h800000 with res_ready=1 -> next cycle res_valid=1, res_data=32'h3F80_0000; popped, res_count=1.
REQ-037 Push s=1, exp=8'h85, mant=24'h000000 -> res_data=32'h0000_0000.
REQ-038 Push exp=8'hFF, s=1, mant=24'hC00000 -> res_data=32'hFF80_0000, flag_ovf=1 and stays 1.
REQ-039 Three back-to-back pushes with res_ready=0 -> in_ready low after the 2nd push, 3rd not latched; then res_ready=1 -> the two words pop in order and count reaches 0.
REQ-040 Count 1 with push and pop in the same cycle -> count stays 1, output order is preserved; push mant=24'h400000 -> flag_unnorm=1.
REQ-041 Assert rst with 2 entries stored -> next cycle res_valid=0, in_ready=1, res_count=0; build without FP_PACK_STATS_EN -> flags and res_count are always 0.
